unidade_controle: RTL and testbench

//  Multi-cycle control FSM of the processor; sits directly upstream of multiplexador and drives its

---
 rtl/proc_pkg.sv | 109 ++++++++++
 rtl/unidade_controle_if.sv | 34 +++
 rtl/unidade_controle_dec3to8.sv | 15 +
 rtl/unidade_controle.sv | 82 ++++++++
 tb/tb_unidade_controle.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/proc_pkg.sv
// proc_pkg: shared definitions for the processor control path.
//   - instruction field positions and widths
//   - opcode values (OP_MV .. OP_AND)
//   - control FSM state encoding (2 bits)
//   - ALU operation codes
//   - ctrl_t: the registered control word the FSM presents each step,
//     plus the helpers that decode it.
// Optional feature: when CTRL_AND_EN is defined, opcode 100 is a 3-step AND.
// When it is not defined, opcode 100 behaves as a NOP.
package proc_pkg;

  localparam int INSTR_W = 16;
  localparam int IMM_W   = 10;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 13;
  localparam int RX_MSB  = 12;
  localparam int RX_LSB  = 10;
  localparam int RY_MSB  = 9;
  localparam int RY_LSB  = 7;
  localparam int IMM_MSB = 9;
  localparam int IMM_LSB = 0;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_T1   = 2'd1,
    ST_T2   = 2'd2,
    ST_T3   = 2'd3
  } state_t;

  // rin_en asks for the one-hot decode of rx; the decode itself lives in dec3to8.
  typedef struct packed {
    logic [2:0] select;
    logic       rselect;
    logic       immeselect;
    logic       rin_en;
    logic       ain;
    logic       gin;
    logic [1:0] alu_op;
    logic       done;
  } ctrl_t;

  function automatic logic is_alu_op(input logic [2:0] op);
    logic r;
    r = (op == OP_ADD) || (op == OP_SUB);
`ifdef CTRL_AND_EN
    r = r || (op == OP_AND);
`endif
    return r;
  endfunction

  function automatic logic [1:0] alu_code(input logic [2:0] op);
    logic [1:0] r;
    r = ALU_ADD;
    if (op == OP_SUB) r = ALU_SUB;
`ifdef CTRL_AND_EN
    if (op == OP_AND) r = ALU_AND;
`endif
    return r;
  endfunction

  // Control word presented while the FSM sits in state st for the given instruction.
  function automatic ctrl_t ctrl_decode(input state_t st, input logic [2:0] op,
                                        input logic [2:0] rx, input logic [2:0] ry);
    ctrl_t c;
    c = '0;
    case (st)
      ST_T1: begin
        if (op == OP_MV) begin
          c.select = ry;
          c.rin_en = 1'b1;
          c.done   = 1'b1;
        end else if (op == OP_MVI) begin
          c.immeselect = 1'b1;
          c.rin_en     = 1'b1;
          c.done       = 1'b1;
        end else if (is_alu_op(op)) begin
          c.select = rx;
          c.ain    = 1'b1;
        end else begin
          c.done = 1'b1;
        end
      end
      ST_T2: begin
        c.select = ry;
        c.gin    = 1'b1;
        c.alu_op = alu_code(op);
      end
      ST_T3: begin
        c.rselect = 1'b1;
        c.rin_en  = 1'b1;
        c.done    = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/unidade_controle_if.sv
// unidade_controle_if: instruction request and datapath control bundle.
//   run, instr          : start request and instruction word (into the control unit)
//   imediato            : IR[9:0] for the multiplexador immediate input
//   select/rSelect/immeSelect : multiplexador source selection
//   rin, irin, ain, gin : register / IR / A / G load enables
//   alu_op, done        : ALU operation and end-of-instruction pulse
// modport master: the control unit side; modport slave: the requester/datapath side.
interface unidade_controle_if;
  import proc_pkg::*;

  logic               run;
  logic [INSTR_W-1:0] instr;
  logic [IMM_W-1:0]   imediato;
  logic [2:0]         select;
  logic               rSelect;
  logic               immeSelect;
  logic [7:0]         rin;
  logic               irin;
  logic               ain;
  logic               gin;
  logic [1:0]         alu_op;
  logic               done;

  modport master (
    input  run, instr,
    output imediato, select, rSelect, immeSelect, rin, irin, ain, gin, alu_op, done
  );

  modport slave (
    output run, instr,
    input  imediato, select, rSelect, immeSelect, rin, irin, ain, gin, alu_op, done
  );

endinterface

// File: rtl/unidade_controle_dec3to8.sv
// dec3to8: 3-bit binary to 8-bit one-hot decoder (register write enable from rx).
//   sel    in  3 : register index
//   onehot out 8 : bit sel set, all others clear
module dec3to8 (
  input  logic [2:0] sel,
  output logic [7:0] onehot
);

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_bit
      assign onehot[gi] = (sel == 3'(gi));
    end
  endgenerate

endmodule

// File: rtl/unidade_controle.sv
// unidade_controle: multi-cycle control FSM of the processor.
// Latches one instruction per accepted run pulse and sequences it over 1-3 steps,
// driving the multiplexador selects and the register/A/G/IR load enables, and
// pulses done in the final step.
//   clock  in : system clock, rising edge
//   resetn in : asynchronous active-low reset
//   bus       : unidade_controle_if.master (run/instr in, control outputs out)
// Optional feature macro: CTRL_AND_EN (opcode 100 executes as AND; otherwise NOP).
module unidade_controle
  import proc_pkg::*;
(
  input  logic               clock,
  input  logic               resetn,
  unidade_controle_if.master bus
);

  state_t             state_reg;
  logic [INSTR_W-1:0] ir_reg;
  ctrl_t              ctrl_reg;
  logic [7:0]         rx_onehot;

  dec3to8 u_dec (
    .sel    (ir_reg[RX_MSB:RX_LSB]),
    .onehot (rx_onehot)
  );

  // The control word is registered together with the state: on every transition
  // the word for the state being entered is loaded, so the outputs follow state
  // and IR only and carry no combinational path from run.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg <= ST_IDLE;
      ir_reg    <= '0;
      ctrl_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.run) begin
            ir_reg    <= bus.instr;
            state_reg <= ST_T1;
            ctrl_reg  <= ctrl_decode(ST_T1, bus.instr[OP_MSB:OP_LSB],
                                     bus.instr[RX_MSB:RX_LSB], bus.instr[RY_MSB:RY_LSB]);
          end else begin
            ctrl_reg <= '0;
          end
        end
        ST_T1: begin
          if (is_alu_op(ir_reg[OP_MSB:OP_LSB])) begin
            state_reg <= ST_T2;
            ctrl_reg  <= ctrl_decode(ST_T2, ir_reg[OP_MSB:OP_LSB],
                                     ir_reg[RX_MSB:RX_LSB], ir_reg[RY_MSB:RY_LSB]);
          end else begin
            state_reg <= ST_IDLE;
            ctrl_reg  <= '0;
          end
        end
        ST_T2: begin
          state_reg <= ST_T3;
          ctrl_reg  <= ctrl_decode(ST_T3, ir_reg[OP_MSB:OP_LSB],
                                   ir_reg[RX_MSB:RX_LSB], ir_reg[RY_MSB:RY_LSB]);
        end
        default: begin
          state_reg <= ST_IDLE;
          ctrl_reg  <= '0;
        end
      endcase
    end
  end

  assign bus.imediato   = ir_reg[IMM_MSB:IMM_LSB];
  assign bus.select     = ctrl_reg.select;
  assign bus.rSelect    = ctrl_reg.rselect;
  assign bus.immeSelect = ctrl_reg.immeselect;
  assign bus.rin        = ctrl_reg.rin_en ? rx_onehot : 8'h00;
  assign bus.ain        = ctrl_reg.ain;
  assign bus.gin        = ctrl_reg.gin;
  assign bus.alu_op     = ctrl_reg.alu_op;
  assign bus.done       = ctrl_reg.done;
  // The only output that follows run; gated by resetn so it reads 0 while reset is held.
  assign bus.irin       = resetn && (state_reg == ST_IDLE) && bus.run;

endmodule

// File: tb/tb_unidade_controle.sv
// tb_unidade_controle: scoreboard bench for unidade_controle.
// Stimulus pushes the expected step sequence of every accepted instruction;
// a negedge monitor pops one record whenever the DUT presents a step.
module tb_unidade_controle;

`ifdef CTRL_AND_EN
  localparam bit AND_EN = 1'b1;
`else
  localparam bit AND_EN = 1'b0;
`endif

  logic clock;
  logic resetn;

  unidade_controle_if bus ();

  unidade_controle dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    logic [27:0] vec;
    logic [15:0] ins;
  } exp_t;

  exp_t exp_q[$];
  int   cyc        = 0;
  int   model_free = 0;
  logic exp_irin   = 1'b0;
  int   n_checks   = 0;
  int   n_fail     = 0;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  function automatic logic [27:0] pack_step(input logic [2:0] sel, input logic rs,
      input logic is, input logic [7:0] rin, input logic a, input logic g,
      input logic [1:0] op, input logic d, input logic [9:0] imm);
    return {sel, rs, is, rin, a, g, op, d, imm};
  endfunction

  function automatic logic [27:0] dut_vec();
    return {bus.select, bus.rSelect, bus.immeSelect, bus.rin, bus.ain, bus.gin,
            bus.alu_op, bus.done, bus.imediato};
  endfunction

  task automatic push(input int c, input logic [27:0] v, input logic [15:0] ins);
    exp_t e;
    e.cyc = c;
    e.vec = v;
    e.ins = ins;
    exp_q.push_back(e);
  endtask

  // Reference model: the instruction accepted at the end of cycle c produces these steps.
  task automatic model_accept(input int c, input logic [15:0] ins);
    int         op  = int'(ins[15:13]);
    logic [2:0] rx  = ins[12:10];
    logic [2:0] ry  = ins[9:7];
    logic [9:0] imm = ins[9:0];
    logic [7:0] oh  = 8'(1 << rx);
    bit         alu = (op == 2) || (op == 3) || (AND_EN && op == 4);
    logic [1:0] aop = (op == 2) ? 2'd0 : (op == 3) ? 2'd1 : 2'd2;
    if (op == 0) begin
      push(c + 1, pack_step(ry, 0, 0, oh, 0, 0, 2'd0, 1, imm), ins);
      model_free = c + 2;
    end else if (op == 1) begin
      push(c + 1, pack_step(3'd0, 0, 1, oh, 0, 0, 2'd0, 1, imm), ins);
      model_free = c + 2;
    end else if (alu) begin
      push(c + 1, pack_step(rx, 0, 0, 8'h00, 1, 0, 2'd0, 0, imm), ins);
      push(c + 2, pack_step(ry, 0, 0, 8'h00, 0, 1, aop, 0, imm), ins);
      push(c + 3, pack_step(3'd0, 1, 0, oh, 0, 0, 2'd0, 1, imm), ins);
      model_free = c + 4;
    end else begin
      push(c + 1, pack_step(3'd0, 0, 0, 8'h00, 0, 0, 2'd0, 1, imm), ins);
      model_free = c + 2;
    end
  endtask

  // One stimulus cycle: drive run/instr just after the edge, model acceptance.
  task automatic drive_cycle(input logic r, input logic [15:0] i);
    @(posedge clock);
    #1;
    bus.run   = r;
    bus.instr = i;
    exp_irin  = r && (cyc >= model_free);
    if (exp_irin) model_accept(cyc, i);
  endtask

  task automatic check_zero(input string nm);
    logic [28:0] got;
    got = {dut_vec(), bus.irin};
    n_checks++;
    if (got !== 29'h0) begin
      n_fail++;
      $display("FAIL %s: outputs=%h required=0", nm, got);
    end
  endtask

  // Monitor: irin every cycle; a step record whenever any control output is active.
  initial forever begin
    logic [27:0] got;
    logic        act;
    exp_t        e;
    @(negedge clock);
    if (resetn === 1'b1) begin
      n_checks++;
      if (bus.irin !== exp_irin) begin
        n_fail++;
        $display("FAIL irin cyc=%0d: got %b required %b", cyc, bus.irin, exp_irin);
      end
      got = dut_vec();
      act = |got[27:10];
      if (act) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_step cyc=%0d: got %h required no step", cyc, got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e.vec || cyc != e.cyc) begin
            n_fail++;
            $display("FAIL step ins=%h: got %h at cyc %0d required %h at cyc %0d",
                     e.ins, got, cyc, e.vec, e.cyc);
          end else begin
            $display("step ins=%h cyc=%0d ctrl=%h ok", e.ins, cyc, got);
          end
        end
      end
    end
  end

  initial begin
    bus.run   = 1'b0;
    bus.instr = 16'h0000;
    resetn    = 1'b0;
    #1;
    check_zero("power_on_reset");
    repeat (2) @(posedge clock);
    #1;
    resetn     = 1'b1;
    model_free = cyc;

    // Reset while an add is in T2.
    drive_cycle(1'b1, 16'h4500);
    drive_cycle(1'b0, 16'h0000);
    drive_cycle(1'b0, 16'h0000);
    n_checks++;
    if (bus.gin !== 1'b1 || bus.alu_op !== 2'b00) begin
      n_fail++;
      $display("FAIL add_t2_before_reset: gin=%b alu_op=%b required gin=1 alu_op=00",
               bus.gin, bus.alu_op);
    end
    bus.run  = 1'b1;
    resetn   = 1'b0;
    exp_irin = 1'b0;
    exp_q.delete();
    #1;
    check_zero("async_reset_mid_t2");
    repeat (2) @(posedge clock);
    #1;
    bus.run    = 1'b0;
    resetn     = 1'b1;
    model_free = cyc;
    #1;
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_after_reset: got %b required 0", bus.done);
    end

    // Directed: mvi, mv, sub, add R3,R3, opcodes 100 and 111.
    drive_cycle(1'b1, 16'h2955);
    drive_cycle(1'b0, 16'h0000);
    drive_cycle(1'b1, 16'h1480);
    drive_cycle(1'b0, 16'h0000);
    drive_cycle(1'b1, 16'h6380);
    repeat (4) drive_cycle(1'b0, 16'h0000);
    drive_cycle(1'b1, 16'h4D80);
    repeat (4) drive_cycle(1'b0, 16'h0000);
    drive_cycle(1'b1, 16'h9A00);
    repeat (4) drive_cycle(1'b0, 16'h0000);
    drive_cycle(1'b1, 16'hE3FF);
    repeat (2) drive_cycle(1'b0, 16'h0000);

    // run held high with instr changing every cycle: one IR load per instruction.
    drive_cycle(1'b1, 16'h4D80);
    drive_cycle(1'b1, 16'h2955);
    drive_cycle(1'b1, 16'h1480);
    drive_cycle(1'b1, 16'h6380);
    drive_cycle(1'b1, 16'h2955);
    drive_cycle(1'b1, 16'h9A00);
    drive_cycle(1'b1, 16'h1480);
    repeat (4) drive_cycle(1'b0, 16'h0000);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive_cycle(($urandom_range(0, 3) != 0), 16'($urandom));
    end

    repeat (6) drive_cycle(1'b0, 16'h0000);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d steps outstanding, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
